prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: writable 16x8 program memory with a byte-stream loader.
//
// The host streams 16 instruction bytes over a valid/ready handshake while
// the CPU is held in reset. Once the program is complete the CPU is released
// and fetches instructions combinationally through addr/instruction.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   - a 17th byte must equal the 8-bit sum of the 16 program bytes;
//               a mismatch parks the loader in ERROR with the CPU still held.
//   undefined - the 16th byte releases the CPU directly; error is tied to 0.
//
// Ports:
//   refclk       in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   load_start   in   request to (re)start loading; honoured in IDLE/RUN/ERROR
//   byte_in      in   instruction byte (7:4 opcode, 3:0 immediate)
//   byte_valid   in   byte_in carries a byte
//   byte_ready   out  loader accepts a byte this cycle (decoded from state)
//   addr         in   CPU fetch address
//   instruction  out  mem[addr], combinational
//   cpu_hold     out  registered; high holds the CPU in reset
//   load_addr    out  index of the next program byte to be written
//   done         out  registered; high while the program is released
//   error        out  registered; checksum mismatch flag
module prog_loader (
    input  logic       refclk,
    input  logic       reset,
    input  logic       load_start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [3:0] addr,
    output logic [7:0] instruction,
    output logic       cpu_hold,
    output logic [3:0] load_addr,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     state;
    logic [7:0] mem [16];
    logic       xfer;

    assign byte_ready  = (state == S_LOAD) || (state == S_CHECK);
    assign xfer        = byte_valid && byte_ready;
    assign instruction = mem[addr];

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Program store. Only LOAD-state transfers write; the checksum byte
    // accepted in CHECK is never stored.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (xfer && state == S_LOAD) begin
            mem[load_addr] <= byte_in;
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            load_addr <= 4'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= 8'h00;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state     <= S_LOAD;
                        load_addr <= 4'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum       <= 8'h00;
`endif
                    end
                end

                S_LOAD: begin
                    if (xfer) begin
                        // 4-bit index wraps to 0 after the 16th byte
                        load_addr <= load_addr + 4'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum       <= sum + byte_in;
                        if (load_addr == 4'd15) state <= S_CHECK;
`else
                        if (load_addr == 4'd15) begin
                            state    <= S_RUN;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end
`endif
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (byte_in == sum) begin
                            state    <= S_RUN;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            error_q  <= 1'b1;
                        end
                    end
                end

                S_ERROR: begin
                    if (load_start) begin
                        state     <= S_LOAD;
                        load_addr <= 4'd0;
                        sum       <= 8'h00;
                        error_q   <= 1'b0;
                    end
                end
`endif

                S_RUN: begin
                    // Memory is kept; the next load overwrites it in place.
                    if (load_start) begin
                        state     <= S_LOAD;
                        load_addr <= 4'd0;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum       <= 8'h00;
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. A transaction-level model (program
// image array, accepted-byte count, running sum, phase flags) predicts every
// observable output; stimulus bytes, stall lengths and fetch addresses are
// drawn with $urandom.
module tb_prog_loader;

    logic       refclk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [3:0] addr = 4'd0;
    logic       byte_ready, cpu_hold, done, error;
    logic [7:0] instruction;
    logic [3:0] load_addr;

    int n_chk = 0;
    int n_pass = 0;

    // reference model
    logic [7:0] ref_mem [16];
    int         ref_cnt;
    int         ref_sum;
    bit         ref_loading, ref_run, ref_err;

    prog_loader dut (
        .refclk      (refclk),
        .reset       (reset),
        .load_start  (load_start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .addr        (addr),
        .instruction (instruction),
        .cpu_hold    (cpu_hold),
        .load_addr   (load_addr),
        .done        (done),
        .error       (error)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_cnt = 0; ref_sum = 0;
        ref_loading = 0; ref_run = 0; ref_err = 0;
    endtask

    task automatic check_outs(input string tag);
        logic [3:0] a;
        chk({tag, ".hold"},  {31'd0, cpu_hold},   {31'd0, !ref_run});
        chk({tag, ".done"},  {31'd0, done},       {31'd0, ref_run});
        chk({tag, ".error"}, {31'd0, error},      {31'd0, ref_err});
        chk({tag, ".ready"}, {31'd0, byte_ready}, {31'd0, ref_loading});
        chk({tag, ".laddr"}, {28'd0, load_addr},  ref_cnt % 16);
        a = 4'($urandom_range(0, 15));
        addr = a;
        #1;
        chk({tag, ".instr"}, {24'd0, instruction}, {24'd0, ref_mem[a]});
    endtask

    task automatic pulse_start(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        if (!ref_loading) begin
            ref_loading = 1; ref_run = 0; ref_err = 0;
            ref_cnt = 0; ref_sum = 0;
        end
        check_outs(tag);
    endtask

    // Present byte b after `stalls` idle cycles; during stalls load_start may
    // be waved at the loader while it is busy (it must be ignored).
    task automatic send(input logic [7:0] b, input int stalls, input bit junk, input string tag);
        for (int s = 0; s < stalls; s++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            load_start = junk && ref_loading && ($urandom_range(0, 1) == 1);
            tick();
            load_start = 1'b0;
            check_outs({tag, ".stall"});
        end
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
        if (ref_loading) begin
            if (ref_cnt < 16) begin
                ref_mem[ref_cnt] = b;
                ref_sum = (ref_sum + int'(b)) % 256;
                ref_cnt++;
`ifndef PROG_LOADER_CHECKSUM_EN
                if (ref_cnt == 16) begin
                    ref_loading = 0; ref_run = 1; ref_cnt = 0;
                end
`endif
            end else begin
                ref_loading = 0; ref_cnt = 0;
                if (int'(b) == ref_sum) ref_run = 1;
                else ref_err = 1;
            end
        end
        check_outs(tag);
    endtask

    initial begin
        logic [7:0] good;
        logic [7:0] bad;
        model_clear();

        // reset with no clock edge
        #1 reset = 1'b1;
        #2;
        check_outs("rst");
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #0.1;
            chk("rst.mem", {24'd0, instruction}, 32'h0);
        end
        @(negedge refclk);
        reset = 1'b0;
        tick();
        check_outs("idle");

        // bytes offered in IDLE are not consumed
        send(8'h55, 0, 0, "idle.byte");

        // full load 8'h30..8'h3F, no stalls
        pulse_start("full.start");
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 0, 0, "full");
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h78, 0, 0, "full.ck");
`endif
        chk("full.done", {31'd0, done}, 32'd1);
        chk("full.hold", {31'd0, cpu_hold}, 32'd0);
        addr = 4'd5;
        #1;
        chk("full.addr5", {24'd0, instruction}, 32'h35);

        // load_start in RUN raises cpu_hold at the next edge
        pulse_start("run.restart");

        // explicit 3-cycle stall mid-stream, junk load_start while loading
        for (int i = 0; i < 16; i++) send(8'($urandom), (i == 8) ? 3 : 0, 1, "stall3");
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'(ref_sum), 0, 0, "stall3.ck");
`endif

        // randomized loads with random stalls
        for (int r = 0; r < 6; r++) begin
            if (!ref_loading) pulse_start("rnd.start");
            for (int i = 0; i < 16; i++)
                send(8'($urandom), $urandom_range(0, 3), 1, "rnd");
`ifdef PROG_LOADER_CHECKSUM_EN
            good = 8'(ref_sum);
            bad  = good ^ 8'($urandom_range(1, 255));
            send(($urandom_range(0, 1) == 1) ? good : bad, $urandom_range(0, 2), 1, "rnd.ck");
`endif
            send(8'($urandom), 0, 0, "rnd.after");
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        // checksum pass: 16 x 8'h11 then 8'h10
        if (!ref_loading) pulse_start("ckp.start");
        for (int i = 0; i < 16; i++) send(8'h11, 0, 0, "ckp");
        send(8'h10, 0, 0, "ckp.ck");
        chk("ckp.done", {31'd0, done}, 32'd1);
        chk("ckp.err", {31'd0, error}, 32'd0);

        // checksum fail: same stream then 8'h11
        pulse_start("ckf.start");
        for (int i = 0; i < 16; i++) send(8'h11, 0, 0, "ckf");
        send(8'h11, 0, 0, "ckf.ck");
        chk("ckf.err", {31'd0, error}, 32'd1);
        chk("ckf.hold", {31'd0, cpu_hold}, 32'd1);
        pulse_start("ckf.restart");
        chk("ckf.clr", {31'd0, error}, 32'd0);
`endif

        // reset after 7 bytes of a load
        if (!ref_loading) pulse_start("mid.start");
        for (int i = 0; i < 7; i++) send(8'($urandom_range(1, 255)), 0, 0, "mid");
        reset = 1'b1;
        #1;
        model_clear();
        check_outs("mid.rst");
        for (int i = 0; i < 7; i++) begin
            addr = 4'(i);
            #0.1;
            chk("mid.mem", {24'd0, instruction}, 32'h0);
        end
        @(negedge refclk);
        reset = 1'b0;
        tick();
        check_outs("mid.idle");
        pulse_start("mid.reload");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
